mem_router: RTL and testbench

- Parametrised successor to the CPU/RAM/IO data steering block.
- Decodes each CPU access to the IO space (below IO_LIMIT) or to RAM (at or above IO_LIMIT).
- Adds a valid/ready CPU handshake, a registered RAM read path, IO wait states with a timeout, and a self-sequencing boot loader.
- The boot loader copies a boot image into RAM before the CPU is released.
- Sits between the CPU core, the synchronous RAM, the IO bus and the boot source.

---
 rtl/mem_router.sv | 173 +++++++++++++++++
 tb/tb_mem_router.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_router.sv
// CPU/RAM/IO steering with boot-image loader, registered RAM read path and IO timeout.
// Define MEM_ROUTER_WP_EN to write-protect the boot region after boot and add wp_fault.
//
// state   | meaning
// BOOT    | copying boot image into RAM, CPU held off
// IDLE    | accepting CPU requests; RAM writes complete here
// RAM_RD  | RAM read data returning, acknowledge CPU
// IO_WAIT | IO strobe held until io_ready or timeout
module mem_router #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 8,
    parameter logic [ADDR_W-1:0] IO_LIMIT   = 'h0100,
    parameter int                BOOT_LEN   = 256,
    parameter int                IO_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_do,
    output logic [DATA_W-1:0] cpu_di,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do,
    output logic [ADDR_W-1:0] io_addr,
    output logic              io_re,
    output logic              io_we,
    output logic [DATA_W-1:0] io_di,
    input  logic [DATA_W-1:0] io_do,
    input  logic              io_ready,
    input  logic [DATA_W-1:0] boot_data,
    input  logic              boot_valid,
    output logic              boot_ready,
    output logic              booting,
    output logic              io_fault
`ifdef MEM_ROUTER_WP_EN
    ,
    output logic              wp_fault
`endif
);

    localparam int CNT_W = $clog2(BOOT_LEN + 1);
    localparam int TMO_W = $clog2(IO_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(IO_TIMEOUT - 1);

    typedef enum logic [1:0] {BOOT, IDLE, RAM_RD, IO_WAIT} state_t;

    state_t            state;
    logic [CNT_W-1:0]  boot_cnt;
    logic [TMO_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] req_addr;
    logic              boot_acc;
    logic              req_valid;
    logic              req_io;
    logic              wp_hit;

    assign boot_ready = (state == BOOT) && !rst;
    assign boot_acc   = boot_ready && boot_valid;
    // cpu_ready high means the CPU is still dropping its previous request
    assign req_valid  = (state == IDLE) && !cpu_ready && (cpu_re || cpu_we) && !rst;
    assign req_io     = cpu_addr < IO_LIMIT;

`ifdef MEM_ROUTER_WP_EN
    localparam logic [ADDR_W:0] WP_SPAN = (ADDR_W+1)'(BOOT_LEN);
    logic [ADDR_W-1:0] wp_off;
    // Modular offset so the protected window follows the wrapping boot addresses
    assign wp_off = cpu_addr - IO_LIMIT;
    assign wp_hit = ({1'b0, wp_off} < WP_SPAN);
`else
    assign wp_hit = 1'b0;
`endif

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = req_addr;
        ram_di   = cpu_do;
        case (state)
            BOOT: begin
                ram_addr = IO_LIMIT + ADDR_W'(boot_cnt);
                ram_di   = boot_data;
                ram_we   = boot_acc;
            end
            IDLE: begin
                ram_addr = cpu_addr;
                ram_we   = req_valid && cpu_we && !req_io && !wp_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            booting   <= 1'b1;
            boot_cnt  <= '0;
            wait_cnt  <= '0;
            req_addr  <= '0;
            cpu_ready <= 1'b0;
            cpu_di    <= '0;
            io_addr   <= '0;
            io_di     <= '0;
            io_re     <= 1'b0;
            io_we     <= 1'b0;
            io_fault  <= 1'b0;
`ifdef MEM_ROUTER_WP_EN
            wp_fault  <= 1'b0;
`endif
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                BOOT: begin
                    if (boot_acc) begin
                        boot_cnt <= boot_cnt + 1'b1;
                        if (boot_cnt == BOOT_LAST) begin
                            state   <= IDLE;
                            booting <= 1'b0;
                        end
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        req_addr <= cpu_addr;
                        if (req_io) begin
                            io_addr  <= cpu_addr;
                            io_di    <= cpu_do;
                            io_re    <= cpu_re;
                            io_we    <= cpu_we;
                            wait_cnt <= TMO_LOAD;
                            state    <= IO_WAIT;
                        end else if (cpu_re) begin
                            state <= RAM_RD;
                        end else begin
                            cpu_ready <= 1'b1;
`ifdef MEM_ROUTER_WP_EN
                            if (wp_hit)
                                wp_fault <= 1'b1;
`endif
                        end
                    end
                end
                RAM_RD: begin
                    cpu_di    <= ram_do;
                    cpu_ready <= 1'b1;
                    state     <= IDLE;
                end
                IO_WAIT: begin
                    // io_ready wins over a simultaneous timeout
                    if (io_ready || wait_cnt == '0) begin
                        cpu_ready <= 1'b1;
                        io_re     <= 1'b0;
                        io_we     <= 1'b0;
                        state     <= IDLE;
                        if (io_ready) begin
                            if (io_re)
                                cpu_di <= io_do;
                        end else begin
                            cpu_di   <= '1;
                            io_fault <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_router.sv
// Directed bench for mem_router with BOOT_LEN=4, IO_LIMIT=0x100, IO_TIMEOUT=15.
module tb_mem_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_re, cpu_we;
    logic [7:0]  cpu_do, cpu_di;
    logic        cpu_ready;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_di, ram_do;
    logic [15:0] io_addr;
    logic        io_re, io_we;
    logic [7:0]  io_di, io_do;
    logic        io_ready;
    logic [7:0]  boot_data;
    logic        boot_valid, boot_ready, booting, io_fault;
`ifdef MEM_ROUTER_WP_EN
    logic        wp_fault;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] ram_mem [0:65535];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we)
            ram_mem[ram_addr] <= ram_di;
        ram_do <= ram_mem[ram_addr];
    end

    mem_router #(
        .ADDR_W(16), .DATA_W(8), .IO_LIMIT(16'h0100), .BOOT_LEN(4), .IO_TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_do(cpu_do),
        .cpu_di(cpu_di), .cpu_ready(cpu_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do),
        .io_addr(io_addr), .io_re(io_re), .io_we(io_we), .io_di(io_di),
        .io_do(io_do), .io_ready(io_ready),
        .boot_data(boot_data), .boot_valid(boot_valid), .boot_ready(boot_ready),
        .booting(booting), .io_fault(io_fault)
`ifdef MEM_ROUTER_WP_EN
        , .wp_fault(wp_fault)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues a RAM read and checks data two cycles later, then releases the request.
    task automatic ram_read(input logic [15:0] a, input logic [7:0] exp, input string nm);
        cpu_re = 1'b1; cpu_addr = a;
        tick;
        total_cnt++;
        if (cpu_ready !== 1'b0) $display("FAIL %s_early_ready: got %b want 0", nm, cpu_ready); else pass_cnt++;
        tick;
        total_cnt++;
        if (cpu_ready !== 1'b1 || cpu_di !== exp)
            $display("FAIL %s: ready=%b data=%h want ready=1 data=%h", nm, cpu_ready, cpu_di, exp);
        else pass_cnt++;
        cpu_re = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        repeat (2) tick;
        boot_valid = 1'b1; boot_data = 8'hEE;
        #1;
        total_cnt++;
        if (booting !== 1'b1 || cpu_ready !== 1'b0 || cpu_di !== 8'h00 || io_fault !== 1'b0)
            $display("FAIL reset_flags: booting=%b ready=%b di=%h fault=%b want 1 0 00 0", booting, cpu_ready, cpu_di, io_fault);
        else pass_cnt++;
        total_cnt++;
        if (ram_we !== 1'b0 || io_re !== 1'b0 || io_we !== 1'b0)
            $display("FAIL reset_strobes: ram_we=%b io_re=%b io_we=%b want 000", ram_we, io_re, io_we);
        else pass_cnt++;
        total_cnt++;
        if (ram_addr !== 16'h0100) $display("FAIL reset_ram_addr: got %h want 0100", ram_addr); else pass_cnt++;
        boot_valid = 1'b0;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_boot;
        logic [7:0]  bw [4];
        logic [15:0] ea;
        bw[0] = 8'hA1; bw[1] = 8'hA2; bw[2] = 8'hA3; bw[3] = 8'hA4;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                boot_valid = 1'b0;
                #1;
                total_cnt++;
                if (ram_we !== 1'b0) $display("FAIL boot_bubble_we: got %b want 0", ram_we); else pass_cnt++;
                tick;
            end
            boot_valid = 1'b1; boot_data = bw[i];
            ea = 16'h0100 + 16'(i);
            #1;
            total_cnt++;
            if (ram_we !== 1'b1 || ram_addr !== ea || ram_di !== bw[i] || booting !== 1'b1)
                $display("FAIL boot_word%0d: we=%b addr=%h di=%h booting=%b want 1 %h %h 1", i, ram_we, ram_addr, ram_di, booting, ea, bw[i]);
            else pass_cnt++;
            tick;
        end
        boot_valid = 1'b0;
        #1;
        total_cnt++;
        if (booting !== 1'b0) $display("FAIL boot_done: booting=%b want 0", booting); else pass_cnt++;
        ram_read(16'h0102, 8'hA3, "boot_read_0102");
    endtask

    task automatic test_decode;
        cpu_re = 1'b1; cpu_addr = 16'h00FF;
        tick;
        total_cnt++;
        if (io_re !== 1'b1 || io_we !== 1'b0 || io_addr !== 16'h00FF)
            $display("FAIL decode_io_00ff: io_re=%b io_we=%b io_addr=%h want 1 0 00ff", io_re, io_we, io_addr);
        else pass_cnt++;
        tick;
        tick;
        io_ready = 1'b1; io_do = 8'h5C;
        tick;
        total_cnt++;
        if (cpu_ready !== 1'b1 || cpu_di !== 8'h5C || io_re !== 1'b0)
            $display("FAIL decode_io_data: ready=%b di=%h io_re=%b want 1 5c 0", cpu_ready, cpu_di, io_re);
        else pass_cnt++;
        cpu_re = 1'b0; io_ready = 1'b0;
        tick;
        cpu_re = 1'b1; cpu_addr = 16'h0100;
        #1;
        total_cnt++;
        if (ram_addr !== 16'h0100) $display("FAIL decode_ram_addr: got %h want 0100", ram_addr); else pass_cnt++;
        tick;
        total_cnt++;
        if (io_re !== 1'b0) $display("FAIL decode_ram_no_io: io_re=%b want 0", io_re); else pass_cnt++;
        tick;
        total_cnt++;
        if (cpu_ready !== 1'b1 || cpu_di !== 8'hA1)
            $display("FAIL decode_ram_0100: ready=%b di=%h want 1 a1", cpu_ready, cpu_di);
        else pass_cnt++;
        cpu_re = 1'b0;
        tick;
    endtask

    task automatic test_ram_write;
        cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_do = 8'h3C;
        #1;
        total_cnt++;
        if (ram_we !== 1'b1 || ram_addr !== 16'h0200 || ram_di !== 8'h3C)
            $display("FAIL ram_write_strobe: we=%b addr=%h di=%h want 1 0200 3c", ram_we, ram_addr, ram_di);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (cpu_ready !== 1'b1 || ram_we !== 1'b0)
            $display("FAIL ram_write_ack: ready=%b we=%b want 1 0", cpu_ready, ram_we);
        else pass_cnt++;
        cpu_we = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        cpu_re = 1'b1; cpu_addr = 16'h0200;
        tick;
        tick;
        total_cnt++;
        if (cpu_ready !== 1'b1 || cpu_di !== 8'h3C)
            $display("FAIL b2b_first: ready=%b di=%h want 1 3c", cpu_ready, cpu_di);
        else pass_cnt++;
        tick;
        cpu_addr = 16'h0100;
        total_cnt++;
        if (cpu_ready !== 1'b0) $display("FAIL b2b_gap: ready=%b want 0", cpu_ready); else pass_cnt++;
        tick;
        tick;
        total_cnt++;
        if (cpu_ready !== 1'b1 || cpu_di !== 8'hA1)
            $display("FAIL b2b_second: ready=%b di=%h want 1 a1", cpu_ready, cpu_di);
        else pass_cnt++;
        cpu_re = 1'b0;
        tick;
    endtask

    task automatic test_io_write;
        cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_do = 8'h42;
        tick;
        total_cnt++;
        if (io_we !== 1'b1 || io_re !== 1'b0 || io_di !== 8'h42 || io_addr !== 16'h0010)
            $display("FAIL io_write_strobe: we=%b re=%b di=%h addr=%h want 1 0 42 0010", io_we, io_re, io_di, io_addr);
        else pass_cnt++;
        io_ready = 1'b1; io_do = 8'h99;
        tick;
        total_cnt++;
        if (cpu_ready !== 1'b1 || cpu_di !== 8'hA1 || io_we !== 1'b0)
            $display("FAIL io_write_done: ready=%b di=%h io_we=%b want 1 a1 0", cpu_ready, cpu_di, io_we);
        else pass_cnt++;
        cpu_we = 1'b0; io_ready = 1'b0;
        tick;
    endtask

    task automatic test_timeout_edge;
        logic early;
        early = 1'b0;
        cpu_re = 1'b1; cpu_addr = 16'h0020;
        tick;
        for (int k = 0; k < 14; k++) begin
            if (cpu_ready) early = 1'b1;
            tick;
        end
        total_cnt++;
        if (early !== 1'b0 || io_re !== 1'b1)
            $display("FAIL edge_wait: early_ready=%b io_re=%b want 0 1", early, io_re);
        else pass_cnt++;
        io_ready = 1'b1; io_do = 8'h96;
        tick;
        total_cnt++;
        if (cpu_ready !== 1'b1 || cpu_di !== 8'h96 || io_fault !== 1'b0)
            $display("FAIL edge_complete: ready=%b di=%h fault=%b want 1 96 0", cpu_ready, cpu_di, io_fault);
        else pass_cnt++;
        cpu_re = 1'b0; io_ready = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        logic early;
        early = 1'b0;
        cpu_re = 1'b1; cpu_addr = 16'h0030;
        tick;
        for (int k = 0; k < 14; k++) begin
            if (cpu_ready) early = 1'b1;
            tick;
        end
        total_cnt++;
        if (early !== 1'b0 || io_re !== 1'b1)
            $display("FAIL timeout_wait: early_ready=%b io_re=%b want 0 1", early, io_re);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (cpu_ready !== 1'b1 || cpu_di !== 8'hFF || io_fault !== 1'b1 || io_re !== 1'b0)
            $display("FAIL timeout_done: ready=%b di=%h fault=%b io_re=%b want 1 ff 1 0", cpu_ready, cpu_di, io_fault, io_re);
        else pass_cnt++;
        cpu_re = 1'b0;
        tick;
        ram_read(16'h0101, 8'hA2, "post_timeout_read");
        total_cnt++;
        if (io_fault !== 1'b1) $display("FAIL timeout_sticky: fault=%b want 1", io_fault); else pass_cnt++;
    endtask

    task automatic test_reset_mid_boot;
        logic [7:0]  bw [4];
        logic [15:0] ea;
        bw[0] = 8'hD1; bw[1] = 8'hD2; bw[2] = 8'hD3; bw[3] = 8'hD4;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (booting !== 1'b1 || io_fault !== 1'b0 || cpu_di !== 8'h00)
            $display("FAIL rst_async: booting=%b fault=%b di=%h want 1 0 00", booting, io_fault, cpu_di);
        else pass_cnt++;
        tick;
        rst = 1'b0;
        tick;
        boot_valid = 1'b1; boot_data = 8'hC1;
        tick;
        boot_data = 8'hC2;
        tick;
        boot_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (booting !== 1'b1) $display("FAIL rst_mid_booting: booting=%b want 1", booting); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            boot_valid = 1'b1; boot_data = bw[i];
            ea = 16'h0100 + 16'(i);
            #1;
            total_cnt++;
            if (ram_we !== 1'b1 || ram_addr !== ea)
                $display("FAIL reboot_word%0d: we=%b addr=%h want 1 %h", i, ram_we, ram_addr, ea);
            else pass_cnt++;
            tick;
        end
        boot_valid = 1'b0;
        #1;
        total_cnt++;
        if (booting !== 1'b0) $display("FAIL reboot_done: booting=%b want 0", booting); else pass_cnt++;
        ram_read(16'h0100, 8'hD1, "reboot_read_0100");
    endtask

`ifdef MEM_ROUTER_WP_EN
    task automatic test_write_protect;
        cpu_we = 1'b1; cpu_addr = 16'h0101; cpu_do = 8'h77;
        #1;
        total_cnt++;
        if (ram_we !== 1'b0) $display("FAIL wp_blocked: ram_we=%b want 0", ram_we); else pass_cnt++;
        tick;
        total_cnt++;
        if (cpu_ready !== 1'b1 || wp_fault !== 1'b1)
            $display("FAIL wp_ack: ready=%b wp_fault=%b want 1 1", cpu_ready, wp_fault);
        else pass_cnt++;
        cpu_we = 1'b0;
        tick;
        ram_read(16'h0101, 8'hD2, "wp_read_0101");
        cpu_we = 1'b1; cpu_addr = 16'h0104; cpu_do = 8'h55;
        #1;
        total_cnt++;
        if (ram_we !== 1'b1) $display("FAIL wp_outside: ram_we=%b want 1", ram_we); else pass_cnt++;
        tick;
        cpu_we = 1'b0;
        tick;
        ram_read(16'h0104, 8'h55, "wp_read_0104");
    endtask
`else
    task automatic test_no_protect;
        cpu_we = 1'b1; cpu_addr = 16'h0101; cpu_do = 8'h77;
        #1;
        total_cnt++;
        if (ram_we !== 1'b1) $display("FAIL boot_region_write: ram_we=%b want 1", ram_we); else pass_cnt++;
        tick;
        cpu_we = 1'b0;
        tick;
        ram_read(16'h0101, 8'h77, "boot_region_read");
    endtask
`endif

    initial begin
        rst = 1'b1;
        cpu_addr = '0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_do = '0;
        io_do = '0; io_ready = 1'b0;
        boot_data = '0; boot_valid = 1'b0;
        test_reset;
        test_boot;
        test_decode;
        test_ram_write;
        test_back_to_back;
        test_io_write;
        test_timeout_edge;
        test_timeout;
        test_reset_mid_boot;
`ifdef MEM_ROUTER_WP_EN
        test_write_protect;
`else
        test_no_protect;
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
